// File: rtl/multicycle_ctrl_fsm_if.sv
// Control/handshake bundle between the multi-cycle sequencer and the RV32I datapath/memory.
// master = sequencer side, slave = datapath/memory side.
interface multicycle_ctrl_fsm_if #(
    parameter int unsigned CNT_W = 32
);
    logic [6:0]       opcode;
    logic             zero;
    logic             mem_ready;
    logic             mem_read;
    logic             mem_write;
    logic             i_or_d;
    logic             ir_write;
    logic             pc_write;
    logic             pc_write_cond;
    logic             pc_src;
    logic [1:0]       alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic             mem_to_reg;
    logic             reg_write;
    logic             illegal_instr;
    logic             instr_done;
    logic [CNT_W-1:0] retired;
    logic             halted;

    modport master (
        input  opcode, zero, mem_ready,
        output mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond, pc_src,
               alu_src_a, alu_src_b, alu_op, mem_to_reg, reg_write,
               illegal_instr, instr_done, retired, halted
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond, pc_src,
               alu_src_a, alu_src_b, alu_op, mem_to_reg, reg_write,
               illegal_instr, instr_done, retired, halted
    );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB over one shared memory port,
// retired-instruction counter and memory-stall watchdog that parks the core in HALT.
module multicycle_ctrl_fsm #(
    parameter int unsigned STALL_LIMIT = 15,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    multicycle_ctrl_fsm_if.master  bus
);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam int unsigned      WAIT_W      = (STALL_LIMIT > 0) ? $clog2(STALL_LIMIT + 1) : 1;
    localparam logic [WAIT_W-1:0] STALL_LIM_W = WAIT_W'(STALL_LIMIT);
    localparam logic             LIMIT_EN    = (STALL_LIMIT != 0) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [6:0]        op_q;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  retired_q;
    logic              halted_q;
    logic              stall_expired_s;

    logic       mem_read_s, mem_write_s, i_or_d_s, ir_write_s, pc_write_s;
    logic       pc_write_cond_s, pc_src_s, mem_to_reg_s, reg_write_s;
    logic       illegal_s, done_s;
    logic [1:0] alu_src_a_s, alu_src_b_s, alu_op_s;

    function automatic logic op_supported(input logic [6:0] op);
        logic ok;
        case (op)
            OP_R, OP_I, OP_LD, OP_ST, OP_BEQ: ok = 1'b1;
            default:                          ok = 1'b0;
        endcase
        return ok;
    endfunction

    assign stall_expired_s = LIMIT_EN && (wait_cnt_q == STALL_LIM_W) && !bus.mem_ready;

    // Next-state selection and wait counter update
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (bus.mem_ready)        state_d = S_DECODE;
                else if (stall_expired_s) state_d = S_HALT;
                else                      state_d = S_FETCH;
            end
            S_DECODE: begin
                if (op_supported(bus.opcode)) state_d = S_EXEC;
                else                          state_d = S_FETCH;
            end
            S_EXEC: begin
                case (op_q)
                    OP_R, OP_I:   state_d = S_WB;
                    OP_LD, OP_ST: state_d = S_MEM;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (bus.mem_ready)        state_d = (op_q == OP_LD) ? S_WB : S_FETCH;
                else if (stall_expired_s) state_d = S_HALT;
                else                      state_d = S_MEM;
            end
            S_WB:    state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase

        if (((state_q == S_FETCH) || (state_q == S_MEM)) && !bus.mem_ready && (state_d == state_q)) begin
            wait_cnt_d = wait_cnt_q + {{(WAIT_W-1){1'b0}}, 1'b1};
        end else begin
            wait_cnt_d = '0;
        end
    end

    // Strobe and mux decode from the current state, latched opcode and live inputs
    always_comb begin
        mem_read_s      = 1'b0;
        mem_write_s     = 1'b0;
        i_or_d_s        = 1'b0;
        ir_write_s      = 1'b0;
        pc_write_s      = 1'b0;
        pc_write_cond_s = 1'b0;
        pc_src_s        = 1'b0;
        alu_src_a_s     = 2'b00;
        alu_src_b_s     = 2'b00;
        alu_op_s        = 2'b00;
        mem_to_reg_s    = 1'b0;
        reg_write_s     = 1'b0;
        illegal_s       = 1'b0;
        done_s          = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read_s  = 1'b1;
                alu_src_b_s = 2'b01;
                ir_write_s  = bus.mem_ready;
                pc_write_s  = bus.mem_ready;
            end
            S_DECODE: begin
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b10;
                // PC was already advanced in FETCH, so an illegal opcode still retires
                if (!op_supported(bus.opcode)) begin
                    illegal_s = 1'b1;
                    done_s    = 1'b1;
                end else begin
                    illegal_s = 1'b0;
                    done_s    = 1'b0;
                end
            end
            S_EXEC: begin
                alu_src_a_s = 2'b10;
                case (op_q)
                    OP_R: begin
                        alu_src_b_s = 2'b00;
                        alu_op_s    = 2'b10;
                    end
                    OP_I: begin
                        alu_src_b_s = 2'b10;
                        alu_op_s    = 2'b10;
                    end
                    OP_LD, OP_ST: begin
                        alu_src_b_s = 2'b10;
                        alu_op_s    = 2'b00;
                    end
                    OP_BEQ: begin
                        alu_src_b_s     = 2'b00;
                        alu_op_s        = 2'b01;
                        pc_write_cond_s = 1'b1;
                        pc_src_s        = 1'b1;
                        done_s          = 1'b1;
                    end
                    default: begin
                        alu_src_b_s = 2'b00;
                        alu_op_s    = 2'b00;
                    end
                endcase
            end
            S_MEM: begin
                i_or_d_s    = 1'b1;
                mem_read_s  = (op_q == OP_LD);
                mem_write_s = (op_q == OP_ST);
                done_s      = bus.mem_ready && (op_q == OP_ST);
            end
            S_WB: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = (op_q == OP_LD);
                done_s       = 1'b1;
            end
            S_HALT: begin
                done_s = 1'b0;
            end
            default: begin
                done_s = 1'b0;
            end
        endcase
    end

    // Sequencer state, latched opcode, stall watchdog, retire counter and halt flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_FETCH;
            op_q       <= 7'd0;
            wait_cnt_q <= '0;
            retired_q  <= '0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (state_q == S_DECODE) begin
                op_q <= bus.opcode;
            end else begin
                op_q <= op_q;
            end
            if (done_s) begin
                retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                retired_q <= retired_q;
            end
            halted_q <= halted_q | (state_d == S_HALT);
        end
    end

    // Reset gates every strobe so an in-flight access is withdrawn without waiting for a clock
    assign bus.mem_read      = mem_read_s      & ~rst;
    assign bus.mem_write     = mem_write_s     & ~rst;
    assign bus.i_or_d        = i_or_d_s        & ~rst;
    assign bus.ir_write      = ir_write_s      & ~rst;
    assign bus.pc_write      = pc_write_s      & ~rst;
    assign bus.pc_write_cond = pc_write_cond_s & ~rst;
    assign bus.pc_src        = pc_src_s        & ~rst;
    assign bus.alu_src_a     = alu_src_a_s     & {2{~rst}};
    assign bus.alu_src_b     = alu_src_b_s     & {2{~rst}};
    assign bus.alu_op        = alu_op_s        & {2{~rst}};
    assign bus.mem_to_reg    = mem_to_reg_s    & ~rst;
    assign bus.reg_write     = reg_write_s     & ~rst;
    assign bus.illegal_instr = illegal_s       & ~rst;
    assign bus.instr_done    = done_s          & ~rst;
    assign bus.retired       = retired_q;
    assign bus.halted        = halted_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Randomized scoreboard bench for multicycle_ctrl_fsm: per-instruction expectations are
// queued by the stimulus and matched by a monitor at every instr_done pulse.
module tb_multicycle_ctrl_fsm;
    localparam int CNT_W = 32;
    localparam int PH_NONE = -1, PH_F = 0, PH_D = 1, PH_E = 2, PH_M = 3, PH_W = 4;
    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                           OP_ST = 7'b0100011, OP_BEQ = 7'b1100011;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multicycle_ctrl_fsm_if #(.CNT_W(CNT_W)) bus();
    multicycle_ctrl_fsm #(.STALL_LIMIT(15), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int cyc; int n_rd; int n_wr; int n_rw; int n_pcc; int n_ill; int n_m2r;
        logic [CNT_W-1:0] ret;
    } exp_t;

    exp_t sb_q[$];
    int checks = 0, errors = 0;
    int ph = PH_NONE;
    logic [6:0] ph_op = 7'd0;
    bit mon_en = 1'b0;
    logic [CNT_W-1:0] retired_model = '0;
    int a_cyc, a_rd, a_wr, a_rw, a_pcc, a_ill, a_m2r, a_ir, a_pcw;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_legal(input logic [6:0] op);
        return (op == OP_R) || (op == OP_I) || (op == OP_LD) || (op == OP_ST) || (op == OP_BEQ);
    endfunction

    // {i_or_d, alu_src_a, alu_src_b, alu_op, pc_src} expected in each phase
    function automatic logic [7:0] exp_mux(input int p, input logic [6:0] op);
        case (p)
            PH_F: return 8'b0_00_01_00_0;
            PH_D: return 8'b0_01_10_00_0;
            PH_E: begin
                if (op == OP_R)                       return 8'b0_10_00_10_0;
                else if (op == OP_I)                  return 8'b0_10_10_10_0;
                else if (op == OP_LD || op == OP_ST)  return 8'b0_10_10_00_0;
                else                                  return 8'b0_10_00_01_1;
            end
            PH_M:    return 8'b1_00_00_00_0;
            default: return 8'b0_00_00_00_0;
        endcase
    endfunction

    task automatic clear_acc();
        a_cyc = 0; a_rd = 0; a_wr = 0; a_rw = 0; a_pcc = 0; a_ill = 0; a_m2r = 0; a_ir = 0; a_pcw = 0;
    endtask

    // Monitor: accumulate strobe activity per instruction, compare on instr_done
    always @(negedge clk) begin
        exp_t e;
        if (rst || !mon_en) begin
            clear_acc();
        end else begin
            a_cyc++;
            a_rd  += int'(bus.mem_read);
            a_wr  += int'(bus.mem_write);
            a_rw  += int'(bus.reg_write);
            a_pcc += int'(bus.pc_write_cond);
            a_ill += int'(bus.illegal_instr);
            a_m2r += int'(bus.reg_write & bus.mem_to_reg);
            a_ir  += int'(bus.ir_write);
            a_pcw += int'(bus.pc_write);
            if (ph != PH_NONE)
                check("mux_word", {bus.i_or_d, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_src},
                      exp_mux(ph, ph_op));
            if (bus.instr_done) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("latency", a_cyc, e.cyc);
                    check("mem_read_cycles", a_rd, e.n_rd);
                    check("mem_write_cycles", a_wr, e.n_wr);
                    check("reg_write_cycles", a_rw, e.n_rw);
                    check("pc_write_cond", a_pcc, e.n_pcc);
                    check("illegal_pulses", a_ill, e.n_ill);
                    check("mem_to_reg_wb", a_m2r, e.n_m2r);
                    check("ir_write", a_ir, 1);
                    check("pc_write", a_pcw, 1);
                    check("retired", bus.retired, e.ret);
                    check("halted", bus.halted, 0);
                end
                clear_acc();
            end
        end
    end

    task automatic step(input logic rdy);
        bus.mem_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    // kind: 0 R, 1 I, 2 LOAD, 3 STORE, 4 BEQ, 5 illegal(ill_op)
    task automatic run_instr(input int kind, input int fw, input int mw, input logic [6:0] ill_op, input logic z);
        exp_t e;
        logic [6:0] opc;
        bit legal, ldst, has_wb;
        case (kind)
            0: opc = OP_R;
            1: opc = OP_I;
            2: opc = OP_LD;
            3: opc = OP_ST;
            4: opc = OP_BEQ;
            default: opc = ill_op;
        endcase
        legal  = is_legal(opc);
        ldst   = (opc == OP_LD) || (opc == OP_ST);
        has_wb = (opc == OP_R) || (opc == OP_I) || (opc == OP_LD);
        e.cyc   = fw + 2 + (legal ? (1 + (ldst ? mw + 1 : 0) + (has_wb ? 1 : 0)) : 0);
        e.n_rd  = fw + 1 + ((opc == OP_LD) ? mw + 1 : 0);
        e.n_wr  = (opc == OP_ST) ? mw + 1 : 0;
        e.n_rw  = has_wb ? 1 : 0;
        e.n_pcc = (opc == OP_BEQ) ? 1 : 0;
        e.n_ill = legal ? 0 : 1;
        e.n_m2r = (opc == OP_LD) ? 1 : 0;
        e.ret   = retired_model;
        retired_model = retired_model + 1;
        sb_q.push_back(e);

        bus.opcode = opc;
        bus.zero   = z;
        ph_op      = opc;
        ph = PH_F;
        for (int i = 0; i < fw; i++) step(1'b0);
        step(1'b1);
        ph = PH_D;
        step(1'($urandom));
        if (legal) begin
            bus.opcode = 7'($urandom);
            ph = PH_E;
            step(1'($urandom));
            if (ldst) begin
                ph = PH_M;
                for (int i = 0; i < mw; i++) step(1'b0);
                step(1'b1);
            end
            if (has_wb) begin
                ph = PH_W;
                step(1'($urandom));
            end
        end
    endtask

    initial begin
        logic [6:0] ill;
        rst = 1'b1;
        bus.opcode = 7'd0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_read", bus.mem_read, 0);
        check("rst_retired", bus.retired, 0);
        check("rst_halted", bus.halted, 0);
        check("rst_instr_done", bus.instr_done, 0);
        rst = 1'b0;
        mon_en = 1'b1;
        #1;
        check("first_fetch_mem_read", bus.mem_read, 1);

        run_instr(0, 0, 0, 7'd0, 1'b0);
        run_instr(2, 0, 3, 7'd0, 1'b0);
        run_instr(4, 0, 0, 7'd0, 1'b1);
        run_instr(4, 0, 0, 7'd0, 1'b0);
        run_instr(5, 0, 0, 7'b1111111, 1'b0);
        run_instr(3, 0, 0, 7'd0, 1'b0);
        run_instr(1, 2, 0, 7'd0, 1'b1);
        for (int n = 0; n < 250; n++) begin
            ill = 7'($urandom);
            while (is_legal(ill)) ill = 7'($urandom);
            run_instr($urandom_range(0, 5), $urandom_range(0, 4), $urandom_range(0, 4), ill, 1'($urandom));
        end
        ph = PH_NONE;
        mon_en = 1'b0;
        check("scoreboard_drained", sb_q.size(), 0);

        // stall watchdog: 16 FETCH cycles without ready, then HALT
        for (int i = 0; i < 16; i++) begin
            bus.mem_ready = 1'b0;
            @(negedge clk);
            check("stall_fetch_mem_read", bus.mem_read, 1);
            check("stall_not_halted", bus.halted, 0);
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 6; i++) begin
            bus.mem_ready = 1'($urandom);
            bus.opcode = OP_R;
            @(negedge clk);
            check("halt_flag", bus.halted, 1);
            check("halt_strobes", {bus.mem_read, bus.mem_write, bus.ir_write, bus.pc_write,
                                   bus.reg_write, bus.i_or_d, bus.alu_src_a, bus.alu_src_b,
                                   bus.alu_op, bus.instr_done, bus.illegal_instr}, 0);
            check("halt_retired_frozen", bus.retired, retired_model);
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        check("halt_cleared_by_rst", bus.halted, 0);
        check("retired_cleared", bus.retired, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        retired_model = '0;

        // STORE interrupted by reset while in MEM
        bus.opcode = OP_ST;
        step(1'b1);
        step(1'b0);
        step(1'b0);
        bus.mem_ready = 1'b0;
        @(negedge clk);
        check("store_mem_write", bus.mem_write, 1);
        check("store_i_or_d", bus.i_or_d, 1);
        #1;
        rst = 1'b1;
        #1;
        check("rst_drops_mem_write", bus.mem_write, 0);
        check("rst_store_retired", bus.retired, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("post_rst_fetch_read", bus.mem_read, 1);
        check("post_rst_i_or_d", bus.i_or_d, 0);
        @(negedge clk);
        check("post_rst_retired", bus.retired, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
